status_reg_requester: RTL and testbench

Initiator side of the status-register access protocol. Accepts read/write commands from a host, buffers them in a small FIFO, stamps each with a rolling tag and issues them one per cycle to a status register file, honouring that file's freeze signal. Captures read responses one cycle after issue and returns them to the host with the tag. Optionally checks each returned tag against the issued one.

---
 rtl/status_reg_requester.sv | 118 +++++++++++
 tb/tb_status_reg_requester.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/status_reg_requester.sv
// Host-side requester: FIFO-buffered commands issued with rolling tags to a status register file; captures read data one cycle after issue.
// Optional STATUS_REQ_TAG_CHECK_EN builds the sticky tag-mismatch check; otherwise o_tag_err is tied low.
module status_reg_requester #(
  parameter int WORD_WIDTH      = 12,
  parameter int ADDR_WIDTH      = 3,
  parameter int TAG_WIDTH       = 1,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  i_cmd_valid,
  input  logic                  i_cmd_wen,
  input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [WORD_WIDTH-1:0] i_cmd_data,
  output logic                  o_cmd_ready,
  output logic                  o_valid,
  output logic                  o_wen,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [WORD_WIDTH-1:0] o_data,
  output logic [TAG_WIDTH-1:0]  o_tag,
  input  logic                  i_freeze,
  input  logic [WORD_WIDTH-1:0] i_rsp_data,
  input  logic [TAG_WIDTH-1:0]  i_rsp_tag,
  output logic                  o_rd_valid,
  output logic [WORD_WIDTH-1:0] o_rd_data,
  output logic [TAG_WIDTH-1:0]  o_rd_tag,
  output logic                  o_tag_err,
  output logic                  o_busy
);
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int PW    = FIFO_DEPTH_LOG2 + 1;

  typedef struct packed {
    logic                  wen;
    logic [ADDR_WIDTH-1:0] addr;
    logic [WORD_WIDTH-1:0] data;
  } cmd_t;

  cmd_t                 mem [DEPTH];
  cmd_t                 head;
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [TAG_WIDTH-1:0] tag_cnt;
  logic [TAG_WIDTH-1:0] exp_tag;
  logic                 pending;
  logic                 empty;
  logic                 full;
  logic                 push;
  logic                 pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                 (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
  assign push  = i_cmd_valid & ~full;
  assign pop   = ~empty & ~i_freeze;
  assign head  = mem[rd_ptr[PW-2:0]];

  assign o_cmd_ready = ~full;
  assign o_valid     = ~empty;
  assign o_wen       = head.wen;
  assign o_addr      = head.addr;
  assign o_data      = head.data;
  assign o_tag       = tag_cnt;
  assign o_busy      = ~empty | pending;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[PW-2:0]] <= '{wen: i_cmd_wen, addr: i_cmd_addr, data: i_cmd_data};
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // The responder's valid is sticky, so capture is timed purely by the pending flag.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      tag_cnt    <= '0;
      exp_tag    <= '0;
      pending    <= 1'b0;
      o_rd_valid <= 1'b0;
      o_rd_data  <= '0;
      o_rd_tag   <= '0;
    end else begin
      pending    <= pop & ~head.wen;
      o_rd_valid <= pending;
      if (pop) begin
        tag_cnt <= tag_cnt + TAG_WIDTH'(1);
        exp_tag <= tag_cnt;
      end
      if (pending) begin
        o_rd_data <= i_rsp_data;
        o_rd_tag  <= exp_tag;
      end
    end
  end

`ifdef STATUS_REQ_TAG_CHECK_EN
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      o_tag_err <= 1'b0;
    end else if (pending && (i_rsp_tag != exp_tag)) begin
      o_tag_err <= 1'b1;
    end
  end
`else
  logic unused_rsp_tag;
  assign unused_rsp_tag = ^i_rsp_tag;
  assign o_tag_err      = 1'b0;
`endif

endmodule

// File: tb/tb_status_reg_requester.sv
// Directed and random stimulus for status_reg_requester against a queue-based reference of the command stream,
// with a simple register-file responder attached to the request port.
module tb_status_reg_requester;
  localparam int WW = 12;
  localparam int AW = 3;
  localparam int TW = 1;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          arst_n;
  logic          cmd_valid;
  logic          cmd_wen;
  logic [AW-1:0] cmd_addr;
  logic [WW-1:0] cmd_data;
  logic          cmd_ready;
  logic          req_valid;
  logic          req_wen;
  logic [AW-1:0] req_addr;
  logic [WW-1:0] req_data;
  logic [TW-1:0] req_tag;
  logic          freeze;
  logic [WW-1:0] rsp_data = '0;
  logic [TW-1:0] rsp_tag = '0;
  logic          rd_valid;
  logic [WW-1:0] rd_data;
  logic [TW-1:0] rd_tag;
  logic          tag_err;
  logic          busy;
  logic          flip;

  status_reg_requester dut (
    .clk(clk), .arst_n(arst_n),
    .i_cmd_valid(cmd_valid), .i_cmd_wen(cmd_wen), .i_cmd_addr(cmd_addr), .i_cmd_data(cmd_data),
    .o_cmd_ready(cmd_ready),
    .o_valid(req_valid), .o_wen(req_wen), .o_addr(req_addr), .o_data(req_data), .o_tag(req_tag),
    .i_freeze(freeze), .i_rsp_data(rsp_data), .i_rsp_tag(rsp_tag),
    .o_rd_valid(rd_valid), .o_rd_data(rd_data), .o_rd_tag(rd_tag),
    .o_tag_err(tag_err), .o_busy(busy)
  );

  // clock
  always #5 clk = ~clk;

  // register-file responder: read data and tag stay put until the next consumed read
  logic [WW-1:0] rf [8] = '{default: '0};
  always @(posedge clk) begin
    if (req_valid && !freeze) begin
      if (req_wen) rf[req_addr] <= req_data;
      else begin
        rsp_data <= rf[req_addr];
        rsp_tag  <= req_tag ^ TW'(flip);
      end
    end
  end

  // reference model
  typedef struct {
    logic          wen;
    logic [AW-1:0] addr;
    logic [WW-1:0] data;
  } cmd_s;

  cmd_s          cmd_q[$];
  logic [WW-1:0] exp_q[$];
  logic [TW-1:0] tag_q[$];
  int            due_q[$];
  logic          flip_q[$];
  logic [WW-1:0] ref_mem [8] = '{default: '0};
  int            tag_cnt;
  logic          err_exp;
  int            cyc;
  int            n_checks;
  int            n_fail;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic pending_exp();
    foreach (due_q[i]) if (due_q[i] == cyc + 1) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    cmd_q.delete(); exp_q.delete(); tag_q.delete(); due_q.delete(); flip_q.delete();
    tag_cnt = 0;
    err_exp = 1'b0;
  endtask

  task automatic check_reset();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_valid", req_valid, 0);
    chk("rst_wen", req_wen, 0);
    chk("rst_addr", req_addr, 0);
    chk("rst_data", req_data, 0);
    chk("rst_tag", req_tag, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_tag", rd_tag, 0);
    chk("rst_tag_err", tag_err, 0);
    chk("rst_busy", busy, 0);
  endtask

  task automatic check_outputs();
    chk("cmd_ready", cmd_ready, cmd_q.size() < DEPTH);
    chk("req_valid", req_valid, cmd_q.size() != 0);
    if (cmd_q.size() != 0) begin
      chk("req_wen", req_wen, cmd_q[0].wen);
      chk("req_addr", req_addr, cmd_q[0].addr);
      chk("req_data", req_data, cmd_q[0].data);
      chk("req_tag", req_tag, tag_cnt % (1 << TW));
    end
    if (due_q.size() != 0 && due_q[0] == cyc) begin
      chk("rd_valid", rd_valid, 1);
      chk("rd_data", rd_data, exp_q[0]);
      chk("rd_tag", rd_tag, tag_q[0]);
`ifdef STATUS_REQ_TAG_CHECK_EN
      if (flip_q[0]) err_exp = 1'b1;
`endif
      void'(exp_q.pop_front()); void'(tag_q.pop_front());
      void'(due_q.pop_front()); void'(flip_q.pop_front());
    end else begin
      chk("rd_valid", rd_valid, 0);
    end
    chk("tag_err", tag_err, err_exp);
    chk("busy", busy, (cmd_q.size() != 0) || pending_exp());
  endtask

  // driver: called just after a falling edge, returns at the next falling edge
  task automatic step(input logic v, input logic w, input logic [AW-1:0] a,
                      input logic [WW-1:0] d, input logic frz);
    cmd_s c;
    logic push_ok;
    logic consume;
    cmd_valid = v; cmd_wen = w; cmd_addr = a; cmd_data = d; freeze = frz;
    #1;
    check_outputs();
    push_ok = v && (cmd_q.size() < DEPTH);
    consume = (cmd_q.size() != 0) && !frz;
    @(posedge clk);
    cyc++;
    if (consume) begin
      c = cmd_q.pop_front();
      if (c.wen) ref_mem[c.addr] = c.data;
      else begin
        exp_q.push_back(ref_mem[c.addr]);
        tag_q.push_back(TW'(tag_cnt % (1 << TW)));
        due_q.push_back(cyc + 1);
        flip_q.push_back(flip);
      end
      tag_cnt++;
    end
    if (push_ok) begin
      c.wen = w; c.addr = a; c.data = d;
      cmd_q.push_back(c);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic frz);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, frz);
  endtask

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0;
    model_reset();
    arst_n = 1'b0; flip = 1'b0;
    cmd_valid = 1'b0; cmd_wen = 1'b0; cmd_addr = '0; cmd_data = '0; freeze = 1'b0;
    #3;
    check_reset();
    @(negedge clk);
    arst_n = 1'b1;

    // write 0xABC to addr 5, then read it back
    step(1'b1, 1'b1, 3'd5, 12'hABC, 1'b0);
    step(1'b1, 1'b0, 3'd5, 12'h000, 1'b0);
    idle(4, 1'b0);

    // fill the FIFO while frozen, over-push once, then drain
    for (int i = 0; i < 5; i++) step(1'b1, 1'(i % 2), AW'(i + 1), WW'(12'h100 + i), 1'b1);
    idle(3, 1'b1);
    idle(7, 1'b0);

    // read held at the head by a 3-cycle freeze
    step(1'b1, 1'b0, 3'd2, 12'h000, 1'b1);
    idle(3, 1'b1);
    idle(4, 1'b0);

    // three back-to-back reads exercise tag wrap
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, AW'(i + 4), '0, 1'b0);
    idle(4, 1'b0);

    // random traffic
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
           WW'($urandom_range(0, 4095)), 1'($urandom_range(0, 3) == 0));
    idle(8, 1'b0);

    // wrong tag returned by the responder; the error flag must stay sticky afterwards
    flip = 1'b1;
    step(1'b1, 1'b0, 3'd1, '0, 1'b0);
    idle(1, 1'b0);
    flip = 1'b0;
    idle(2, 1'b0);
    step(1'b1, 1'b0, 3'd3, '0, 1'b0);
    idle(4, 1'b0);

    // reset with three queued commands and a read in flight
    step(1'b1, 1'b0, 3'd6, '0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, AW'(i), WW'(12'h5A0 + i), 1'b1);
    idle(1, 1'b0);
    chk("pre_rst_busy", busy, 1);
    arst_n = 1'b0;
    #1;
    check_reset();
    model_reset();
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    idle(5, 1'b0);
    step(1'b1, 1'b0, 3'd5, '0, 1'b0);
    idle(4, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
